// File: rtl/fletcher_pkg.sv
// Shared definitions for the Fletcher checksum verifier: frame states,
// default checksum width and the end-around modulus helper.
package fletcher_pkg;

   localparam int DefaultWidth = 32;

   typedef enum logic [2:0] {
      IDLE,
      PAYLOAD,
      TRAIL_B,
      TRAIL_A,
      DONE
   } state_e;

   // Modulus M = 2^half_width - 1 for one checksum half.
   function automatic logic [63:0] fletcher_modulus(input int half_width);
      return (64'd1 << half_width) - 64'd1;
   endfunction

endpackage

// File: rtl/fletcher_mod_acc.sv
// One Fletcher accumulator lane: acc <= (acc + addend) mod (2^WidthHalf-1)
// using a carry-out end-around add. Both 0 and all-ones stand for zero.
module fletcher_mod_acc
   import fletcher_pkg::*;
#(
   parameter int WidthHalf = DefaultWidth / 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic [WidthHalf-1:0] addend,
   output logic [WidthHalf-1:0] sum_next,
   output logic [WidthHalf-1:0] acc
);

   logic [WidthHalf:0] raw_sum;

   // Inputs never exceed M, so one end-around fold keeps the result <= M.
   always_comb begin
      raw_sum  = {1'b0, acc} + {1'b0, addend};
      sum_next = raw_sum[WidthHalf-1:0] + WidthHalf'(raw_sum[WidthHalf]);
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum_next;
      end
   end

endmodule

// File: rtl/fletcher_verifier.sv
// Fletcher checksum verifier: accumulates len payload words, then compares
// the trailer words B and A against the running sums (mod 2^WidthHalf-1).
// Optional calc register enabled by defining FLETCHER_VERIFIER_CALC_EN.
module fletcher_verifier
   import fletcher_pkg::*;
#(
   parameter  int Width     = DefaultWidth,
   localparam int WidthHalf = Width / 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [15:0]          len,
   input  logic [WidthHalf-1:0] din,
   input  logic                 din_valid,
   output logic                 din_ready,
   output logic                 done,
   output logic                 ok,
   output logic [Width-1:0]     calc
);

   localparam logic [WidthHalf-1:0] Modulus = WidthHalf'(fletcher_modulus(WidthHalf));

   function automatic logic congruent(input logic [WidthHalf-1:0] x,
                                      input logic [WidthHalf-1:0] y);
      return (x == y) || (x == Modulus && y == '0) || (x == '0 && y == Modulus);
   endfunction

   state_e               state;
   state_e               state_next;
   logic [15:0]          remaining;
   logic                 match_b;
   logic                 accept;
   logic                 start_ok;
   logic                 acc_en;
   logic [WidthHalf-1:0] a_acc;
   logic [WidthHalf-1:0] a_next;
   logic [WidthHalf-1:0] b_acc;
   logic [WidthHalf-1:0] b_next;

   assign din_ready = (state == PAYLOAD) || (state == TRAIL_B) || (state == TRAIL_A);
   assign done      = (state == DONE);
   assign accept    = din_valid && din_ready;
   assign start_ok  = start && (state == IDLE);
   assign acc_en    = accept && (state == PAYLOAD);

   fletcher_mod_acc #(.WidthHalf(WidthHalf)) u_acc_a (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_ok),
      .en       (acc_en),
      .addend   (din),
      .sum_next (a_next),
      .acc      (a_acc)
   );

   // B folds in the freshly updated A of the same word.
   fletcher_mod_acc #(.WidthHalf(WidthHalf)) u_acc_b (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_ok),
      .en       (acc_en),
      .addend   (a_next),
      .sum_next (b_next),
      .acc      (b_acc)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (len != 16'd0) ? PAYLOAD : TRAIL_B;
         PAYLOAD: if (accept && remaining == 16'd1) state_next = TRAIL_B;
         TRAIL_B: if (accept) state_next = TRAIL_A;
         TRAIL_A: if (accept) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         match_b   <= 1'b0;
         ok        <= 1'b0;
      end else begin
         state <= state_next;
         if (start_ok) begin
            remaining <= len;
            match_b   <= 1'b0;
            ok        <= 1'b0;
         end else if (acc_en) begin
            remaining <= remaining - 16'd1;
         end
         if (accept && state == TRAIL_B) begin
            match_b <= congruent(din, b_acc);
         end
         if (accept && state == TRAIL_A) begin
            ok <= match_b && congruent(din, a_acc);
         end
      end
   end

`ifdef FLETCHER_VERIFIER_CALC_EN
   logic             last_payload;
   logic [Width-1:0] calc_q;

   assign last_payload = acc_en && (remaining == 16'd1);

   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         calc_q <= '0;
      end else if (last_payload) begin
         calc_q <= {b_next, a_next};
      end
   end

   assign calc = calc_q;
`else
   logic calc_unused;
   assign calc_unused = ^b_next;
   assign calc        = '0;
`endif

endmodule

// File: tb/tb_fletcher_verifier.sv
// Self-checking bench for fletcher_verifier (Width=32): directed frames from
// the requirement list plus randomized frames checked against a mod-M model.
module tb_fletcher_verifier;

   localparam int unsigned M = 65535;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] len;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready;
   logic        done;
   logic        ok;
   logic [31:0] calc;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fletcher_verifier #(.Width(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .done      (done),
      .ok        (ok),
      .calc      (calc)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: plain Fletcher sums modulo 2^16-1, result {B,A} in 0..M-1.
   function automatic logic [31:0] model_sum(input int unsigned words[$]);
      int unsigned a = 0;
      int unsigned b = 0;
      foreach (words[i]) begin
         a = (a + words[i]) % M;
         b = (b + a) % M;
      end
      return {b[15:0], a[15:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input string tag, input logic [15:0] w);
      int gaps = $urandom_range(0, 2);
      repeat (gaps) begin
         din_valid = 1'b0;
         din       = 16'($urandom);
         step();
      end
      din       = w;
      din_valid = 1'b1;
      @(negedge clk);
      check({tag, "_ready"}, 32'(din_ready), 32'd1);
      check({tag, "_done_early"}, 32'(done), 32'd0);
      step();
      din_valid = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int unsigned payload[$],
                            input logic [15:0] trl_b, input logic [15:0] trl_a,
                            input bit inject_start);
      logic [31:0]  exp_sum;
      logic         exp_ok;
      int unsigned  tb_v;
      int unsigned  ta_v;
      int unsigned  calc_b;
      int unsigned  calc_a;
      exp_sum = model_sum(payload);
      tb_v    = trl_b;
      ta_v    = trl_a;
      exp_ok  = ((tb_v % M) == exp_sum[31:16]) && ((ta_v % M) == exp_sum[15:0]);

      start = 1'b1;
      len   = 16'(payload.size());
      step();
      start = 1'b0;
      @(negedge clk);
      check({tag, "_ok_cleared"}, 32'(ok), 32'd0);
      step();

      foreach (payload[i]) begin
         send_word($sformatf("%s_w%0d", tag, i), 16'(payload[i]));
         if (inject_start && i == 0) begin
            start = 1'b1;
            len   = 16'd1;
            step();
            start = 1'b0;
         end
      end
      send_word({tag, "_trl_b"}, trl_b);
      send_word({tag, "_trl_a"}, trl_a);

      @(negedge clk);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_ok"}, 32'(ok), 32'(exp_ok));
      check({tag, "_ready_done"}, 32'(din_ready), 32'd0);
`ifdef FLETCHER_VERIFIER_CALC_EN
      calc_b = calc[31:16];
      calc_a = calc[15:0];
      check({tag, "_calc_b"}, calc_b % M, 32'(exp_sum[31:16]));
      check({tag, "_calc_a"}, calc_a % M, 32'(exp_sum[15:0]));
`else
      calc_b = 0;
      calc_a = 0;
      check({tag, "_calc_off"}, calc, 32'd0);
`endif
      step();
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_ok_held"}, 32'(ok), 32'(exp_ok));
      step();
   endtask

   initial begin
      int unsigned q[$];
      logic [31:0] s;
      logic [15:0] trl_b;
      logic [15:0] trl_a;

      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      din       = '0;
      din_valid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("reset_ready", 32'(din_ready), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_ok", 32'(ok), 32'd0);
      check("reset_calc", calc, 32'd0);
      step();
      rst = 1'b0;
      step();

      q = '{32'h0001, 32'h0002};
      run_frame("basic", q, 16'h0004, 16'h0003, 1'b0);
      run_frame("bad_a", q, 16'h0004, 16'h0002, 1'b0);
      q = '{32'hFFFF, 32'h0001};
      run_frame("wrap", q, 16'h0001, 16'h0001, 1'b0);
      q = {};
      run_frame("len0_ones", q, 16'hFFFF, 16'hFFFF, 1'b0);
      run_frame("len0_zero", q, 16'h0000, 16'h0000, 1'b0);

      // Reset in the middle of a payload, with start and din also active.
      start = 1'b1;
      len   = 16'd5;
      step();
      start = 1'b0;
      send_word("abort_w0", 16'h1234);
      send_word("abort_w1", 16'h5678);
      rst       = 1'b1;
      start     = 1'b1;
      din_valid = 1'b1;
      din       = 16'hABCD;
      step();
      rst       = 1'b0;
      start     = 1'b0;
      din_valid = 1'b0;
      @(negedge clk);
      check("abort_ready", 32'(din_ready), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_ok", 32'(ok), 32'd0);
      check("abort_calc", calc, 32'd0);
      step();
      @(negedge clk);
      check("abort_idle", 32'(din_ready), 32'd0);
      step();
      q = '{32'h0010, 32'h0020, 32'h0030};
      s = model_sum(q);
      run_frame("after_abort", q, s[31:16], s[15:0], 1'b0);

      q = '{32'h1111, 32'h2222, 32'h3333};
      s = model_sum(q);
      run_frame("start_ignored", q, s[31:16], s[15:0], 1'b1);

      for (int n = 0; n < 8; n++) begin
         int unsigned rlen = $urandom_range(1, 8);
         int unsigned mode = $urandom_range(0, 3);
         q = {};
         for (int i = 0; i < int'(rlen); i++) begin
            q.push_back(($urandom_range(0, 4) == 0) ? 32'hFFFF : ($urandom & 32'hFFFF));
         end
         s     = model_sum(q);
         trl_b = s[31:16];
         trl_a = s[15:0];
         if (mode == 1) trl_b = trl_b ^ 16'h0100;
         if (mode == 2) trl_a = trl_a + 16'd1;
         if (mode == 3) begin
            if (trl_b == 16'h0000) trl_b = 16'hFFFF;
            if (trl_a == 16'h0000) trl_a = 16'hFFFF;
         end
         run_frame($sformatf("rand%0d", n), q, trl_b, trl_a, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
